fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction fetch stage feeding the decoder. Holds the fetch PC and issues word requests to instruction memory over a request/grant/response-valid handshake. Buffers returned instructions with their PCs in a small in-order queue. Presents the head entry, plus pre-sliced opcode/funct3/funct7 bit 30, to the decode/control stage under a valid/ready handshake, and flushes on redirects from branch control.

## Interface
- `ADDR_WIDTH`, 32, PC and memory address width
- `RESET_PC`, 32'hBFC00000, first fetch address after reset
- `DEPTH`, 2, queue entries; power of two, ≥2
- `clk_i` in 1: clock; all state updates on rising edge
- `rstn_i` in 1: reset, synchronous, active-low
- `imem_req_o` out 1: fetch request
- `imem_addr_o` out ADDR_WIDTH: request address, word-aligned
- `imem_gnt_i` in 1: request accepted this cycle (meaningful only while `imem_req_o`=1)
- `imem_rvalid_i` in 1: response data valid
- `imem_rdata_i` in 32: response instruction word
- `redirect_i` in 1: flush and restart fetch
- `redirect_pc_i` in ADDR_WIDTH: new fetch address
- `instr_valid_o` out 1: head entry valid
- `instr_ready_i` in 1: decoder accepts head
- `instr_o` out 32: head instruction
- `instr_pc_o` out ADDR_WIDTH: PC of head instruction
- `op_o` out 7: `instr_o[6:0]`
- `funct3_o` out 3: `instr_o[14:12]`
- `funct7bit_o` out 1: `instr_o[30]`

## Operation
- Registered state: `fetch_pc`, `out_pc` (PC of outstanding request), FSM state, queue storage, read/write pointers, `count` (0..DEPTH).
- FSM states:
  - ISSUE: `imem_req_o` = (count < DEPTH); `imem_addr_o` = `fetch_pc`. On `imem_gnt_i`&&`imem_req_o`: `out_pc` ← `fetch_pc`, `fetch_pc` ← `fetch_pc`+4 (mod 2^ADDR_WIDTH), go to WAIT.
  - WAIT: `imem_req_o`=0. On `imem_rvalid_i`: push {`out_pc`, `imem_rdata_i`}, go to ISSUE.
  - DROP: `imem_req_o`=0. On `imem_rvalid_i`: discard data, go to ISSUE.
- At most one request outstanding. Responses arriving in ISSUE are ignored.
- Space check counts the outstanding request, so a push in WAIT never overflows. Request only when count < DEPTH at issue time.
- Pop: `instr_valid_o` && `instr_ready_i`. Push and pop in the same cycle leave `count` unchanged.
- `instr_valid_o` = (count ≠ 0). Outputs come from the queue head, combinationally from registers. Head holds stable while valid && !ready.
- Redirect (highest priority):
  - `count` ← 0, pointers ← 0.
  - `fetch_pc` ← {`redirect_pc_i`[ADDR_WIDTH-1:2], 2'b00}.
  - Any same-cycle push or pop is suppressed.
  - Next state: WAIT→DROP; ISSUE with grant this cycle→DROP; DROP→DROP; otherwise ISSUE.
  - Same-cycle `imem_rvalid_i` in WAIT or DROP completes the outstanding transaction: data discarded, next state ISSUE.
- An ungranted request may change address or drop `imem_req_o` after a redirect. Instruction memory tolerates this.

## Timing
- Reset (`rstn_i`=0 at edge):
  - `fetch_pc`=RESET_PC, state=ISSUE, count=0, queue entries=0.
  - While `rstn_i`=0: `imem_req_o`=0, `instr_valid_o`=0, `instr_o`=0, `instr_pc_o`=0.
  - First request (addr RESET_PC) in the first cycle with `rstn_i`=1.
- Reset mid-transaction abandons the outstanding request. A later `imem_rvalid_i` arrives in ISSUE and is ignored.
- Latency, zero-wait memory (gnt same cycle as req, rvalid next cycle): req at t, rvalid at t+1, `instr_valid_o`=1 at t+2. Next request also at t+2.
- Steady-state throughput: 1 instruction per 2 cycles.
- Redirect at t: `instr_valid_o`=0 at t+1. Request to the new PC at t+1 unless DROP, in which case it follows the cycle after the discarded rvalid.
- Full (count=DEPTH): `imem_req_o`=0. Request reasserts the cycle after a pop.
- PC wraps 32'hFFFFFFFC → 32'h00000000.

## Test plan
- Reset release, zero-wait memory returning addr-as-data, `instr_ready_i`=1:
  - PCs BFC00000, BFC00004, BFC00008 appear at cycles 2, 4, 6.
  - `op_o`/`funct3_o`/`funct7bit_o` match slices of `instr_o`.
- `instr_ready_i`=0 for 10 cycles:
  - count reaches 2, `imem_req_o` stays low, head holds BFC00000.
  - Raising ready drains in order and fetching resumes.
- Grant delayed 3 cycles and rvalid delayed 4 cycles:
  - `imem_addr_o` stable during the wait.
  - Exactly one outstanding request; data pushed with correct PC.
- `redirect_i`, `redirect_pc_i`=0x00000103, while in WAIT with 1 queued entry:
  - `instr_valid_o`=0 next cycle; the late response is discarded.
  - Next request addr=0x00000100; first delivered PC=0x00000100.
- `redirect_pc_i`=0xFFFFFFF8: fetched PCs FFFFFFF8, FFFFFFFC, 00000000.
- Assert `rstn_i`=0 for one cycle while in WAIT, then return stale rvalid:
  - Stale data ignored.
  - First delivered entry is {BFC00000, fresh data}.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch stage: issues word fetches over req/gnt/rvalid, buffers
// {pc, instr} pairs in an in-order queue and presents the head to decode.
module fetch_queue #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'hBFC00000,
  parameter int unsigned           DEPTH      = 2
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [31:0]           imem_rdata_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [31:0]           instr_o,
  output logic [ADDR_WIDTH-1:0] instr_pc_o,
  output logic [6:0]            op_o,
  output logic [2:0]            funct3_o,
  output logic                  funct7bit_o
);

  localparam int unsigned     PW   = $clog2(DEPTH);
  localparam int unsigned     CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]   FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_ISSUE,
    S_WAIT,
    S_DROP
  } state_t;

  state_t                  state, state_n;
  logic [ADDR_WIDTH-1:0]   fetch_pc, fetch_pc_n;
  logic [ADDR_WIDTH-1:0]   out_pc, out_pc_n;
  logic [31:0]             q_instr [DEPTH];
  logic [ADDR_WIDTH-1:0]   q_pc    [DEPTH];
  logic [PW-1:0]           rd_ptr, wr_ptr;
  logic [CW-1:0]           count;
  logic                    granted, push, pop;

  // Space is checked at issue time; the single outstanding request always
  // has a slot reserved because nothing else pushes until it returns.
  assign imem_req_o    = rstn_i && (state == S_ISSUE) && (count < FULL);
  assign imem_addr_o   = fetch_pc;
  assign granted       = imem_req_o && imem_gnt_i;

  assign instr_valid_o = rstn_i && (count != '0);
  assign instr_o       = rstn_i ? q_instr[rd_ptr] : '0;
  assign instr_pc_o    = rstn_i ? q_pc[rd_ptr]    : '0;
  assign op_o          = instr_o[6:0];
  assign funct3_o      = instr_o[14:12];
  assign funct7bit_o   = instr_o[30];

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    out_pc_n   = out_pc;
    push       = 1'b0;
    pop        = 1'b0;
    if (redirect_i) begin
      fetch_pc_n = redirect_pc_i & ~ADDR_WIDTH'(3);
      // A request still in flight must be drained unless it completes now.
      if (state == S_ISSUE) state_n = granted ? S_DROP : S_ISSUE;
      else                  state_n = imem_rvalid_i ? S_ISSUE : S_DROP;
    end else begin
      pop = instr_valid_o && instr_ready_i;
      case (state)
        S_ISSUE: if (granted) begin
          out_pc_n   = fetch_pc;
          fetch_pc_n = fetch_pc + ADDR_WIDTH'(4);
          state_n    = S_WAIT;
        end
        S_WAIT: if (imem_rvalid_i) begin
          push    = 1'b1;
          state_n = S_ISSUE;
        end
        S_DROP: if (imem_rvalid_i) state_n = S_ISSUE;
        default: state_n = S_ISSUE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) state <= S_ISSUE;
    else         state <= state_n;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      fetch_pc <= RESET_PC;
      out_pc   <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else begin
      fetch_pc <= fetch_pc_n;
      out_pc   <= out_pc_n;
      if (redirect_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          q_instr[wr_ptr] <= imem_rdata_i;
          q_pc[wr_ptr]    <= out_pc;
          wr_ptr          <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        if (push && !pop)      count <= count + CW'(1);
        else if (pop && !push) count <= count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table and corner-case sequences, plus
// randomized traffic against a transaction-level queue model.
module tb_fetch_queue;
  localparam int          AW     = 32;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        rstn, imem_req, imem_gnt, imem_rvalid, redirect, instr_valid, instr_ready;
  logic        funct7bit;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc;
  logic [6:0]  op;
  logic [2:0]  funct3;

  always #5 clk = ~clk;

  fetch_queue #(.ADDR_WIDTH(AW), .RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(imem_gnt),
    .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
    .instr_o(instr), .instr_pc_o(instr_pc),
    .op_o(op), .funct3_o(funct3), .funct7bit_o(funct7bit)
  );

  typedef struct { logic [31:0] pc; logic [31:0] data; } entry_t;
  typedef struct { bit ready; bit req; logic [31:0] addr; bit valid; logic [31:0] pc; bit zero_head; } vec_t;

  int vectors = 0;
  int miscompares = 0;

  // reference model: delivered-but-not-consumed entries and the one fetch in flight
  entry_t      exp_q[$];
  bit          out_busy, out_stale;
  logic [31:0] out_pc, out_data, m_fetch_pc;
  logic [31:0] popped[$];

  // instruction memory model
  bit          mem_busy, rand_mem;
  int unsigned rv_cnt, wait_cnt, gnt_delay, rv_delay;
  logic [31:0] mem_data, salt;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ salt;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    bit exp_req;
    if (!rstn) begin
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_pc", instr_pc, 32'd0);
    end else begin
      chk("valid", 32'(instr_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("head_pc", instr_pc, exp_q[0].pc);
        chk("head_instr", instr, exp_q[0].data);
        chk("op", 32'(op), 32'(exp_q[0].data[6:0]));
        chk("funct3", 32'(funct3), 32'(exp_q[0].data[14:12]));
        chk("funct7bit", 32'(funct7bit), 32'(exp_q[0].data[30]));
      end
      exp_req = !out_busy && (exp_q.size() < DEPTH);
      chk("req", 32'(imem_req), 32'(exp_req));
      if (exp_req) chk("addr", imem_addr, m_fetch_pc);
    end
  endtask

  task automatic model_step();
    entry_t e;
    if (!rstn) begin
      exp_q.delete();
      out_busy   = 1'b0;
      out_stale  = 1'b0;
      m_fetch_pc = RST_PC;
      return;
    end
    if (redirect) begin
      exp_q.delete();
      if (out_busy && imem_rvalid) out_busy = 1'b0;
      else if (out_busy)           out_stale = 1'b1;
      if (imem_gnt) begin
        out_busy  = 1'b1;
        out_stale = 1'b1;
      end
      m_fetch_pc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (exp_q.size() != 0 && instr_ready) e = exp_q.pop_front();
      if (out_busy && imem_rvalid) begin
        if (!out_stale) exp_q.push_back('{out_pc, out_data});
        out_busy = 1'b0;
      end
      if (imem_gnt) begin
        out_busy   = 1'b1;
        out_stale  = 1'b0;
        out_pc     = m_fetch_pc;
        out_data   = word(m_fetch_pc);
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
  endtask

  task automatic mem_step();
    if (imem_rvalid)               mem_busy = 1'b0;
    else if (mem_busy && rv_cnt > 0) rv_cnt--;
    if (imem_gnt) begin
      mem_busy = 1'b1;
      rv_cnt   = rv_delay - 1;
      mem_data = word(imem_addr);
      wait_cnt = 0;
      if (rand_mem) begin
        gnt_delay = $urandom_range(0, 3);
        rv_delay  = $urandom_range(1, 4);
      end
    end else if (imem_req && !mem_busy) wait_cnt++;
    else wait_cnt = 0;
  endtask

  // first half of a cycle: memory reacts to req, then outputs are checked
  task automatic cyc_a();
    #1;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (mem_busy && rv_cnt == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_data;
    end
    if (!mem_busy && imem_req && wait_cnt >= gnt_delay) imem_gnt = 1'b1;
    #1;
    check_outputs();
    if (rstn && !redirect && instr_valid && instr_ready) popped.push_back(instr_pc);
  endtask

  task automatic cyc_b();
    model_step();
    mem_step();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    cyc_a();
    cyc_b();
  endtask

  task automatic do_reset();
    rstn = 1'b0; redirect = 1'b0; instr_ready = 1'b0; redirect_pc = '0;
    mem_busy = 1'b0; rand_mem = 1'b0; gnt_delay = 0; rv_delay = 1;
    wait_cnt = 0; rv_cnt = 0; salt = '0;
    cycle();
    cycle();
    rstn = 1'b1;
    popped.delete();
  endtask

  task automatic wait_first_valid(input string name, input logic [31:0] exp_pc, input logic [31:0] exp_data);
    bit seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      cyc_a();
      if (instr_valid) begin
        seen = 1'b1;
        chk({name, "_pc"}, instr_pc, exp_pc);
        chk({name, "_data"}, instr, exp_data);
      end
      cyc_b();
    end
    chk({name, "_seen"}, 32'(seen), 32'd1);
  endtask

  vec_t tbl[8];
  logic [31:0] exp_seq[3];

  initial begin
    bit found, cond, prev_wait;
    logic [31:0] prev_addr;

    tbl[0] = '{1'b1, 1'b1, 32'hBFC00000, 1'b0, 32'h0, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 32'hBFC00004, 1'b1, 32'hBFC00000, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 32'hBFC00008, 1'b1, 32'hBFC00004, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 32'hBFC0000C, 1'b1, 32'hBFC00008, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0, 1'b0};

    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    @(posedge clk);
    #1;

    // reset release, zero-wait memory returning address as data
    do_reset();
    for (int i = 0; i < 8; i++) begin
      instr_ready = tbl[i].ready;
      cyc_a();
      chk("t_req", 32'(imem_req), 32'(tbl[i].req));
      if (tbl[i].req) chk("t_addr", imem_addr, tbl[i].addr);
      chk("t_valid", 32'(instr_valid), 32'(tbl[i].valid));
      if (tbl[i].valid) begin
        chk("t_pc", instr_pc, tbl[i].pc);
        chk("t_instr", instr, tbl[i].pc);
        chk("t_op", 32'(op), 32'(tbl[i].pc[6:0]));
      end
      if (tbl[i].zero_head) begin
        chk("t_zero_instr", instr, 32'd0);
        chk("t_zero_pc", instr_pc, 32'd0);
      end
      cyc_b();
    end

    // decoder stalls: queue fills, request stops, head holds
    do_reset();
    instr_ready = 1'b0;
    repeat (10) cycle();
    cyc_a();
    chk("full_req", 32'(imem_req), 32'd0);
    chk("full_valid", 32'(instr_valid), 32'd1);
    chk("full_head", instr_pc, 32'hBFC00000);
    cyc_b();
    instr_ready = 1'b1;
    cycle();
    cyc_a();
    chk("resume_req", 32'(imem_req), 32'd1);
    chk("resume_addr", imem_addr, 32'hBFC00008);
    chk("drain_head", instr_pc, 32'hBFC00004);
    cyc_b();
    repeat (8) cycle();

    // slow memory: grant after 3 cycles, response 4 cycles later
    do_reset();
    gnt_delay = 3; rv_delay = 4; instr_ready = 1'b1;
    prev_wait = 1'b0; prev_addr = '0;
    for (int n = 0; n < 40; n++) begin
      cyc_a();
      if (prev_wait && imem_req) chk("slow_addr_stable", imem_addr, prev_addr);
      prev_wait = imem_req && !imem_gnt;
      prev_addr = imem_addr;
      cyc_b();
    end
    chk("slow_count", 32'(popped.size() >= 3), 32'd1);
    if (popped.size() >= 3)
      for (int i = 0; i < 3; i++) chk("slow_pc", popped[i], RST_PC + 32'(4 * i));

    // redirect while waiting with one queued entry
    do_reset();
    rv_delay = 3; instr_ready = 1'b0;
    cond = 1'b0;
    for (int n = 0; n < 40 && !cond; n++) begin
      cond = out_busy && (exp_q.size() == 1);
      if (!cond) cycle();
    end
    chk("redir_setup", 32'(cond), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h00000103;
    cycle();
    redirect = 1'b0;
    cyc_a();
    chk("redir_valid", 32'(instr_valid), 32'd0);
    chk("redir_drop_req", 32'(imem_req), 32'd0);
    cyc_b();
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      cyc_a();
      if (imem_req) begin
        found = 1'b1;
        chk("redir_addr", imem_addr, 32'h00000100);
      end
      cyc_b();
    end
    chk("redir_req_seen", 32'(found), 32'd1);
    wait_first_valid("redir_first", 32'h00000100, 32'h00000100);

    // PC wrap at the top of the address space
    do_reset();
    instr_ready = 1'b1;
    repeat (3) cycle();
    redirect = 1'b1; redirect_pc = 32'hFFFFFFF8;
    cycle();
    redirect = 1'b0;
    popped.delete();
    repeat (20) cycle();
    exp_seq[0] = 32'hFFFFFFF8; exp_seq[1] = 32'hFFFFFFFC; exp_seq[2] = 32'h00000000;
    chk("wrap_count", 32'(popped.size() >= 3), 32'd1);
    if (popped.size() >= 3)
      for (int i = 0; i < 3; i++) chk("wrap_pc", popped[i], exp_seq[i]);

    // reset during an outstanding fetch; its late response must be ignored
    do_reset();
    rv_delay = 3; instr_ready = 1'b1;
    cond = 1'b0;
    for (int n = 0; n < 40 && !cond; n++) begin
      cond = out_busy && (out_pc == 32'hBFC00004);
      if (!cond) cycle();
    end
    chk("rstmid_setup", 32'(cond), 32'd1);
    rstn = 1'b0;
    salt = 32'h0F0F0000;
    cycle();
    rstn = 1'b1;
    popped.delete();
    wait_first_valid("rstmid_first", 32'hBFC00000, 32'hBFC00000 ^ 32'h0F0F0000);

    // randomized traffic, delays, redirects and resets
    do_reset();
    rand_mem = 1'b1;
    salt = 32'h13579BDF;
    for (int n = 0; n < 800; n++) begin
      instr_ready = ($urandom_range(0, 9) < 7);
      redirect    = ($urandom_range(0, 39) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 + 32'($urandom_range(0, 15)) : $urandom;
      rstn        = ($urandom_range(0, 199) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    miscompares++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
